// File: rtl/ale_bus_pkg.sv
// Shared types and defaults for the ALE strobe-bus register target.
package ale_bus_pkg;

  localparam int unsigned DEF_DATA_W = 5;
  localparam int unsigned DEF_NREGS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_e;

  // Address width for a bank of n registers (at least one bit).
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ale_bus_target_strobe_edge.sv
// Registered rise/fall detector for one strobe line.
// Ports: clk, rst (sync, active-high), d (strobe level),
//        rise_c / fall_c (combinational edge flags, valid in the first cycle
//        the new level is seen).
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic q;
  logic armed;

  // armed stays low until the line has been seen low after reset, so a
  // strobe that was already high across reset is treated as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= d;
      armed <= armed | ~d;
    end
  end

  assign rise_c = d & ~q & armed;
  assign fall_c = ~d & q;

endmodule

// File: rtl/ale_bus_target.sv
// Register target for the ALE/En/Rw strobe bus: latches an address on ALE,
// writes or reads one register per En pulse, auto-increments the address.
// Ports: clk, rst (sync, active-high), ale, en, rw, bus_in (address/data in),
//        bus_out/bus_oe (read data and drive enable), regs (flat register
//        bank, reg k at [k*DATA_W +: DATA_W]), wr_pulse (cycle after a write),
//        err (one-cycle protocol violation pulse).
module ale_bus_target
  import ale_bus_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ale,
  input  logic                    en,
  input  logic                    rw,
  input  logic [DATA_W-1:0]       bus_in,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_oe,
  output logic [NREGS*DATA_W-1:0] regs,
  output logic                    wr_pulse,
  output logic                    err
);

  localparam int unsigned ADDR_W = addr_width(NREGS);

  logic              ale_rise;
  logic              ale_fall_unused;
  logic              en_rise;
  logic              en_fall;
  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] bank [NREGS];
  logic              addr_ok_c;

  strobe_edge u_ale_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (ale),
    .rise_c (ale_rise),
    .fall_c (ale_fall_unused)
  );

  strobe_edge u_en_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (en),
    .rise_c (en_rise),
    .fall_c (en_fall)
  );

  // Address is accepted only if every bit above the register index is zero.
  assign addr_ok_c = (bus_in[DATA_W-1:ADDR_W] == '0);

  // Protocol FSM, address counter, register bank and read mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      err      <= 1'b0;
      for (int unsigned k = 0; k < NREGS; k++) bank[k] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      err      <= 1'b0;
      if (ale_rise && en_rise) begin
        // Ambiguous strobe pair: flag and ignore both.
        err <= 1'b1;
      end else begin
        if (ale_rise) begin
          case (state)
            IDLE, ADDR: begin
              if (addr_ok_c) begin
                addr  <= bus_in[ADDR_W-1:0];
                state <= ADDR;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
            default: err <= 1'b1;
          endcase
        end
        if (en_rise) begin
          case (state)
            IDLE: err <= 1'b1;
            ADDR: begin
              if (!rw) begin
                bank[addr] <= bus_in;
                wr_pulse   <= 1'b1;
                state      <= WRITE;
              end else begin
                bus_out <= bank[addr];
                bus_oe  <= 1'b1;
                state   <= READ;
              end
            end
            default: ;
          endcase
        end
        if (en_fall && (state == WRITE || state == READ)) begin
          // NREGS is a power of two, so the counter wraps naturally.
          addr   <= addr + ADDR_W'(1);
          bus_oe <= 1'b0;
          state  <= ADDR;
        end
      end
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_regs
    assign regs[k*DATA_W +: DATA_W] = bank[k];
  end

endmodule
